// File: rtl/card_pair_controller.sv
// Memory-game round sequencer: turns card clicks into face-up / matched masks,
// with pair compare, timed mismatch hold, pair and move counting.
module card_pair_controller #(
  parameter int NUM_CARDS   = 16,
  parameter int IDX_W       = 4,
  parameter int VAL_W       = 3,
  parameter int PAIR_W      = 4,
  parameter int HOLD_CYCLES = 65000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       click_valid,
  input  logic [IDX_W-1:0]           click_idx,
  input  logic [NUM_CARDS*VAL_W-1:0] deck,
  output logic [NUM_CARDS-1:0]       revealed,
  output logic [NUM_CARDS-1:0]       matched,
  output logic [PAIR_W-1:0]          pairs_found,
  output logic [7:0]                 moves,
  output logic                       mismatch,
  output logic                       playing,
  output logic                       done
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [PAIR_W-1:0]    ALL_PAIRS = PAIR_W'(NUM_CARDS / 2);
  localparam logic [NUM_CARDS-1:0] ONE       = NUM_CARDS'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_SECOND, S_COMPARE, S_HOLD, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_CARDS-1:0]       revealed_q, revealed_d;
  logic [NUM_CARDS-1:0]       matched_q, matched_d;
  logic [PAIR_W-1:0]          pairs_q, pairs_d;
  logic [7:0]                 moves_q, moves_d;
  logic [NUM_CARDS*VAL_W-1:0] deck_q, deck_d;
  logic [IDX_W-1:0]           first_q, first_d;
  logic [IDX_W-1:0]           second_q, second_d;
  logic [CNT_W-1:0]           hold_q, hold_d;

  logic [NUM_CARDS-1:0] click_mask, pair_mask;
  logic [VAL_W-1:0]     val_a, val_b;
  logic                 click_legal;

  // An out-of-range index shifts the one-hot off the top, leaving an empty mask.
  assign click_mask  = ONE << click_idx;
  assign pair_mask   = (ONE << first_q) | (ONE << second_q);
  assign click_legal = click_valid && (click_mask != '0)
                       && (((revealed_q | matched_q) & click_mask) == '0);
  assign val_a = deck_q[int'(first_q) * VAL_W +: VAL_W];
  assign val_b = deck_q[int'(second_q) * VAL_W +: VAL_W];

  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    matched_d  = matched_q;
    pairs_d    = pairs_q;
    moves_d    = moves_q;
    deck_d     = deck_q;
    first_d    = first_q;
    second_d   = second_q;
    hold_d     = hold_q;

    unique case (state_q)
      S_FIRST: begin
        if (click_legal) begin
          first_d    = click_idx;
          revealed_d = revealed_q | click_mask;
          state_d    = S_SECOND;
        end
      end
      S_SECOND: begin
        if (click_legal) begin
          second_d   = click_idx;
          revealed_d = revealed_q | click_mask;
          state_d    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
        if (val_a == val_b) begin
          matched_d  = matched_q | pair_mask;
          revealed_d = revealed_q & ~pair_mask;
          pairs_d    = pairs_q + 1'b1;
          state_d    = (pairs_d == ALL_PAIRS) ? S_DONE : S_FIRST;
        end else begin
          hold_d  = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          revealed_d = revealed_q & ~pair_mask;
          state_d    = S_FIRST;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: ;
    endcase

    // start overrides whatever the state logic chose, including a same-cycle click.
    if (start) begin
      revealed_d = '0;
      matched_d  = '0;
      pairs_d    = '0;
      moves_d    = '0;
      hold_d     = '0;
      deck_d     = deck;
      state_d    = S_FIRST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      revealed_q <= '0;
      matched_q  <= '0;
      pairs_q    <= '0;
      moves_q    <= '0;
      deck_q     <= '0;
      first_q    <= '0;
      second_q   <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      revealed_q <= revealed_d;
      matched_q  <= matched_d;
      pairs_q    <= pairs_d;
      moves_q    <= moves_d;
      deck_q     <= deck_d;
      first_q    <= first_d;
      second_q   <= second_d;
      hold_q     <= hold_d;
    end
  end

  assign revealed    = revealed_q;
  assign matched     = matched_q;
  assign pairs_found = pairs_q;
  assign moves       = moves_q;
  assign mismatch    = (state_q == S_HOLD);
  assign playing     = (state_q == S_FIRST) || (state_q == S_SECOND)
                       || (state_q == S_COMPARE) || (state_q == S_HOLD);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_card_pair_controller.sv
// Directed bench: a 16-card / 4-cycle-hold instance and a 12-card instance for range checks.
module tb_card_pair_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        click_valid = 1'b0;
  logic [3:0]  click_idx = '0;
  logic [47:0] deck;
  logic [15:0] revealed, matched;
  logic [3:0]  pairs_found;
  logic [7:0]  moves;
  logic        mismatch, playing, done;

  logic        s2_start = 1'b0;
  logic        s2_click_valid = 1'b0;
  logic [3:0]  s2_click_idx = '0;
  logic [35:0] s2_deck;
  logic [11:0] s2_revealed, s2_matched;
  logic [3:0]  s2_pairs_found;
  logic [7:0]  s2_moves;
  logic        s2_mismatch, s2_playing, s2_done;

  int n_checks = 0;
  int n_fail   = 0;

  card_pair_controller #(.NUM_CARDS(16), .IDX_W(4), .VAL_W(3), .PAIR_W(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .click_valid(click_valid), .click_idx(click_idx),
    .deck(deck), .revealed(revealed), .matched(matched), .pairs_found(pairs_found),
    .moves(moves), .mismatch(mismatch), .playing(playing), .done(done)
  );

  card_pair_controller #(.NUM_CARDS(12), .IDX_W(4), .VAL_W(3), .PAIR_W(4), .HOLD_CYCLES(4)) dut12 (
    .clk(clk), .rst(rst), .start(s2_start), .click_valid(s2_click_valid), .click_idx(s2_click_idx),
    .deck(s2_deck), .revealed(s2_revealed), .matched(s2_matched), .pairs_found(s2_pairs_found),
    .moves(s2_moves), .mismatch(s2_mismatch), .playing(s2_playing), .done(s2_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input logic [3:0] idx);
    click_valid = 1'b1;
    click_idx   = idx;
    tick();
    click_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic s2_click(input logic [3:0] idx);
    s2_click_valid = 1'b1;
    s2_click_idx   = idx;
    tick();
    s2_click_valid = 1'b0;
  endtask

  initial begin
    // Card i carries face value i/2, so (2p, 2p+1) are the pairs.
    for (int i = 0; i < 16; i++) deck[i*3 +: 3] = 3'(i / 2);
    for (int i = 0; i < 12; i++) s2_deck[i*3 +: 3] = 3'(i / 2);

    #2;
    chk("rst_revealed", revealed, 0);
    chk("rst_matched", matched, 0);
    chk("rst_pairs", pairs_found, 0);
    chk("rst_moves", moves, 0);
    chk("rst_flags", {mismatch, playing, done}, 0);

    tick();
    rst = 1'b0;
    tick();

    // Clicks in IDLE are ignored.
    click(4'd3);
    chk("idle_revealed", revealed, 0);
    chk("idle_playing", playing, 0);
    chk("idle_done", done, 0);

    pulse_start();
    chk("start_playing", playing, 1);

    // Matching pair.
    click(4'd0);
    chk("m_first_rev", revealed, 16'h0001);
    click(4'd1);
    chk("m_second_rev", revealed, 16'h0003);
    tick();
    chk("m_matched", matched, 16'h0003);
    chk("m_revealed", revealed, 0);
    chk("m_pairs", pairs_found, 1);
    chk("m_moves", moves, 1);

    // Illegal clicks: matched card, then the revealed first card again.
    click(4'd0);
    chk("ill_matched_rev", revealed, 0);
    click(4'd2);
    chk("ill_first_rev", revealed, 16'h0004);
    click(4'd2);
    chk("ill_again_rev", revealed, 16'h0004);
    chk("ill_again_mm", mismatch, 0);

    // Mismatch 2 vs 4: HOLD spans exactly 4 cycles, click during HOLD ignored.
    click(4'd4);
    chk("mm_cmp_rev", revealed, 16'h0014);
    chk("mm_cmp_mm", mismatch, 0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) click(4'd6);
      else tick();
      chk($sformatf("mm_hold%0d_flag", k), mismatch, 1);
      chk($sformatf("mm_hold%0d_rev", k), revealed, 16'h0014);
    end
    tick();
    chk("mm_end_flag", mismatch, 0);
    chk("mm_end_rev", revealed, 0);
    chk("mm_end_moves", moves, 2);
    chk("mm_end_pairs", pairs_found, 1);
    chk("mm_end_playing", playing, 1);

    // Restart mid-game clears everything.
    pulse_start();
    chk("rs_matched", matched, 0);
    chk("rs_moves", moves, 0);
    chk("rs_pairs", pairs_found, 0);

    // Full game with no mistakes.
    for (int p = 0; p < 8; p++) begin
      click(4'(2 * p));
      click(4'(2 * p + 1));
      tick();
    end
    chk("full_done", done, 1);
    chk("full_playing", playing, 0);
    chk("full_matched", matched, 16'hFFFF);
    chk("full_revealed", revealed, 0);
    chk("full_pairs", pairs_found, 8);
    chk("full_moves", moves, 8);
    click(4'd5);
    chk("done_click_done", done, 1);
    chk("done_click_matched", matched, 16'hFFFF);

    pulse_start();
    chk("again_done", done, 0);
    chk("again_playing", playing, 1);
    chk("again_matched", matched, 0);
    chk("again_pairs", pairs_found, 0);
    chk("again_moves", moves, 0);

    // start beats a same-cycle legal click in SECOND.
    click(4'd0);
    chk("sc_first_rev", revealed, 16'h0001);
    start = 1'b1;
    click(4'd1);
    start = 1'b0;
    chk("sc_rev", revealed, 0);
    chk("sc_playing", playing, 1);
    click(4'd1);
    chk("sc_next_rev", revealed, 16'h0002);
    click(4'd3);
    chk("sc_second_rev", revealed, 16'h000A);
    tick();
    chk("sc_hold_mm", mismatch, 1);
    tick();

    // Asynchronous reset in the middle of HOLD.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_revealed", revealed, 0);
    chk("arst_matched", matched, 0);
    chk("arst_moves", moves, 0);
    chk("arst_flags", {mismatch, playing, done}, 0);
    tick();
    rst = 1'b0;
    click(4'd2);
    chk("arst_idle_rev", revealed, 0);
    chk("arst_idle_playing", playing, 0);

    // 12-card instance: index 15 is out of range.
    s2_start = 1'b1;
    tick();
    s2_start = 1'b0;
    s2_click(4'd15);
    chk("c12_oor_first", s2_revealed, 0);
    chk("c12_playing", s2_playing, 1);
    s2_click(4'd11);
    chk("c12_first_rev", s2_revealed, 12'h800);
    s2_click(4'd15);
    chk("c12_oor_second", s2_revealed, 12'h800);
    s2_click(4'd10);
    chk("c12_second_rev", s2_revealed, 12'hC00);
    tick();
    chk("c12_matched", s2_matched, 12'hC00);
    chk("c12_pairs", s2_pairs_found, 1);
    chk("c12_moves", s2_moves, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/card_pair_controller.md
Name: card_pair_controller

Overview:
- Sequences one round of the memory game. Takes card-click events and produces the face-up and matched card masks that the card drawing stage renders.
- Sits between the click event checker for the card grid and the card drawing stage. Clocked on the 65 MHz pixel clock alongside the game state machine.
- Handles first pick, second pick, pair compare, a timed mismatch display hold, pair counting, move counting and end of game.

Parameters:
- NUM_CARDS, 16, cards on the grid; must be even.
- IDX_W, 4, width of a card index; 2**IDX_W >= NUM_CARDS.
- VAL_W, 3, width of a card face value; 2**VAL_W >= NUM_CARDS/2.
- PAIR_W, 4, width of the pair counter; must hold NUM_CARDS/2.
- HOLD_CYCLES, 65000000, clock cycles a mismatched pair stays face-up (1 s at 65 MHz); must be >= 1.

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts a game
- click_valid  in  1  single-cycle pulse; a card was left-clicked
- click_idx  in  IDX_W  index of the clicked card; qualified by click_valid
- deck  in  NUM_CARDS*VAL_W  face value of card i at bits [i*VAL_W +: VAL_W]
- revealed  out  NUM_CARDS  cards face-up and not yet matched
- matched  out  NUM_CARDS  cards removed as matched pairs
- pairs_found  out  PAIR_W  matched pairs this game
- moves  out  8  completed pair attempts; saturates at 255
- mismatch  out  1  high for the whole HOLD state
- playing  out  1  high in FIRST, SECOND, COMPARE and HOLD
- done  out  1  high in DONE

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the internal deck copy, first index, second index and hold counter are all 0.
- States: IDLE, FIRST, SECOND, COMPARE, HOLD, DONE.
- start is accepted in every state and wins over a same-cycle click.
  - On the next edge: revealed, matched, pairs_found, moves and the hold counter are cleared; deck is latched into the internal copy; state becomes FIRST.
  - The deck may change after start without affecting the game in progress.
- A click is legal only when all of the following hold:
  - state is FIRST or SECOND;
  - click_idx < NUM_CARDS;
  - the card's revealed bit and matched bit are both 0.
- Illegal clicks are ignored and change no state.
- FIRST: a legal click stores the first index, sets its revealed bit on the next edge, and moves to SECOND.
- SECOND: a legal click stores the second index, sets its revealed bit on the next edge, and moves to COMPARE. Clicking the first card again is illegal because it is already revealed.
- COMPARE takes exactly one cycle. It compares the two latched deck values and updates moves by +1 (saturating).
  - Equal values: set both matched bits, clear both revealed bits, and increment pairs_found. If the new pairs_found equals NUM_CARDS/2, go to DONE; otherwise go to FIRST.
  - Unequal values: load the hold counter with HOLD_CYCLES-1 and go to HOLD.
- HOLD: clicks are ignored and the counter decrements once per cycle. In the cycle the counter is 0, clear both revealed bits and go to FIRST. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- DONE: holds matched all-ones and revealed all-zeros until start or rst.
- IDLE: ignores clicks; only start leaves it.
- Latencies:
  - click to revealed bit: 1 cycle.
  - second click to matched or mismatch: 2 cycles.
  - mismatch rising to revealed cleared: HOLD_CYCLES cycles.
- rst asserted mid-game (including mid-HOLD) returns everything to the reset values immediately, with no pending update.

Test Plan:
- Reset then idle: rst, then click_valid with idx 3 and no start -> state stays IDLE, revealed=0, playing=0.
- Match: NUM_CARDS=16, HOLD_CYCLES=4, deck values 0,0,1,1,2,2...; start, click 0, click 1 -> revealed 0x0001 after the first click, 0x0003 after the second; 2 cycles after the second click: matched=0x0003, revealed=0, pairs_found=1, moves=1.
- Mismatch: click 0, click 2 -> mismatch high for exactly 4 cycles with revealed=0x0005; then revealed=0, moves=1, pairs_found=0. A click on card 4 during HOLD is ignored.
- Illegal clicks: click an already-matched card, click the revealed first card again, click idx 15 with NUM_CARDS=12 -> no change to revealed or state.
- Full game: match all 8 pairs -> done=1, playing=0, matched=0xFFFF, pairs_found=8, moves=8. A further start -> all cleared and state FIRST.
- Restart and reset: start issued in the same cycle as a legal click during SECOND -> click ignored, game cleared. rst asserted during HOLD -> all outputs 0 and state IDLE before the next edge.
